coefficient_run_sequencer: RTL and testbench

// - Walks one 8x8 block of quantised, zigzag-ordered coefficients and emits JPEG entropy symbols
//   (run, size, amplitude) per F.1.2, using coefficient_encoder for size/amplitude coding.
// - Computes DC differences against per-component predictors and tracks AC zero runs, ZRL and EOB.
// - Sits between the quantiser's coefficient RAM and the Huffman symbol packer.

---
 rtl/coefficient_run_sequencer_pkg.sv | 33 +++
 rtl/coefficient_run_sequencer_encoder.sv | 25 ++
 rtl/coefficient_run_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_coefficient_run_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coefficient_run_sequencer_pkg.sv
// Shared definitions for the JPEG coefficient run sequencer: FSM state type,
// ZRL/EOB symbol constants, block geometry and the size-category helper used by
// the coefficient encoder.
package coefficient_run_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EVAL,
    S_EMIT_ZRL,
    S_EMIT_SYM,
    S_EMIT_EOB,
    S_DONE
  } seq_state_t;

  localparam logic [3:0]  ZRL_RUN   = 4'hf;
  localparam logic [3:0]  EOB_RUN   = 4'h0;
  localparam logic [3:0]  EOB_SIZE  = 4'h0;
  localparam int unsigned BLOCK_LEN = 64;
  localparam logic [5:0]  LAST_IDX  = 6'(BLOCK_LEN - 1);

  // Bit length of a magnitude, clipped to the 4-bit size field. Only a
  // magnitude of 32768 (input -32768) would need 16, which saturates to 15.
  function automatic logic [3:0] coef_size(input logic [15:0] mag);
    logic [4:0] len;
    len = '0;
    for (int unsigned b = 0; b < 16; b++) begin
      if (mag[b]) len = 5'(b + 1);
    end
    return (len > 5'd15) ? 4'd15 : len[3:0];
  endfunction

endpackage

// File: rtl/coefficient_run_sequencer_encoder.sv
// coefficient_encoder: combinational JPEG size/amplitude coder.
//   value_i      in  16  signed value (DC difference or AC coefficient)
//   size_o       out 4   magnitude category (0 for value 0)
//   amplitude_o  out 16  coded bits, low size_o bits meaningful, 0 when size_o==0
// Negative values are coded as value-1 truncated to size_o bits (ones' complement
// of the magnitude).
module coefficient_encoder
  import coefficient_run_sequencer_pkg::*;
(
  input  logic signed [15:0] value_i,
  output logic        [3:0]  size_o,
  output logic        [15:0] amplitude_o
);

  logic [15:0] mag;
  logic [15:0] biased;

  always_comb begin
    mag         = value_i[15] ? 16'(~value_i + 16'd1) : value_i;
    size_o      = coef_size(mag);
    biased      = value_i[15] ? 16'(value_i - 16'sd1) : value_i;
    amplitude_o = biased & ~(16'hFFFF << size_o);
  end

endmodule

// File: rtl/coefficient_run_sequencer.sv
// coefficient_run_sequencer: walks one zigzag-ordered 8x8 block from the
// coefficient RAM and emits JPEG entropy symbols (run, size, amplitude) to the
// Huffman packer: one DC difference symbol, AC symbols with ZRL insertion, and
// EOB when the block ends in zeros.
//   clock, reset        single clock, synchronous active-high reset
//   start, component_id begin a block (only when idle), component latched
//   dc_clear            zero all DC predictors (only when idle)
//   coef_addr/coef_data RAM read port, data valid one cycle after address
//   sym_valid/sym_ready symbol handshake; sym_is_dc, sym_run, sym_size,
//                       sym_amplitude are the symbol fields
//   busy, block_done    block in progress / one-cycle completion pulse
module coefficient_run_sequencer
  import coefficient_run_sequencer_pkg::*;
#(
  parameter int unsigned NUM_COMPONENTS = 3,
  parameter int unsigned COMP_W         = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [COMP_W-1:0]        component_id,
  input  logic                     dc_clear,
  output logic [5:0]               coef_addr,
  input  logic signed [15:0]       coef_data,
  output logic                     sym_valid,
  input  logic                     sym_ready,
  output logic                     sym_is_dc,
  output logic [3:0]               sym_run,
  output logic [3:0]               sym_size,
  output logic [15:0]              sym_amplitude,
  output logic                     busy,
  output logic                     block_done
);

  seq_state_t               state_q, state_d;
  logic [5:0]               idx_q, idx_d;
  logic [3:0]               zero_run_q, zero_run_d;
  logic [1:0]               zrl_pend_q, zrl_pend_d;
  logic [COMP_W-1:0]        comp_q, comp_d;
  logic signed [15:0]       enc_q, enc_d;
  logic                     is_dc_q, is_dc_d;
  logic signed [15:0]       pred_q [NUM_COMPONENTS];
  logic signed [15:0]       pred_d [NUM_COMPONENTS];

  logic signed [15:0]       pred_sel;
  logic [3:0]               enc_size;
  logic [15:0]              enc_amp;

  // The encoder sees only the captured value, so the held symbol is immune to
  // coef_addr/coef_data moving while the packer stalls.
  coefficient_encoder u_enc (
    .value_i     (enc_q),
    .size_o      (enc_size),
    .amplitude_o (enc_amp)
  );

  always_comb begin
    pred_sel = '0;
    for (int unsigned i = 0; i < NUM_COMPONENTS; i++) begin
      if (comp_q == COMP_W'(i)) pred_sel = pred_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    zero_run_d = zero_run_q;
    zrl_pend_d = zrl_pend_q;
    comp_d     = comp_q;
    enc_d      = enc_q;
    is_dc_d    = is_dc_q;
    for (int unsigned i = 0; i < NUM_COMPONENTS; i++) pred_d[i] = pred_q[i];

    sym_valid     = 1'b0;
    sym_is_dc     = 1'b0;
    sym_run       = '0;
    sym_size      = '0;
    sym_amplitude = '0;

    unique case (state_q)
      S_IDLE: begin
        if (dc_clear) begin
          for (int unsigned i = 0; i < NUM_COMPONENTS; i++) pred_d[i] = '0;
        end
        if (start) begin
          comp_d     = component_id;
          idx_d      = '0;
          zero_run_d = '0;
          zrl_pend_d = '0;
          state_d    = S_FETCH;
        end
      end

      S_FETCH: state_d = S_EVAL;

      S_EVAL: begin
        if (idx_q == '0) begin
          // DC: the 2:1 mux into the encoder register selects the difference.
          enc_d   = coef_data - pred_sel;
          is_dc_d = 1'b1;
          for (int unsigned i = 0; i < NUM_COMPONENTS; i++) begin
            if (comp_q == COMP_W'(i)) pred_d[i] = coef_data;
          end
          state_d = S_EMIT_SYM;
        end else if (coef_data == '0) begin
          if (zero_run_q == 4'd15) begin
            zero_run_d = '0;
            zrl_pend_d = zrl_pend_q + 2'd1;
          end else begin
            zero_run_d = zero_run_q + 4'd1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_EMIT_EOB;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_FETCH;
          end
        end else begin
          enc_d   = coef_data;
          is_dc_d = 1'b0;
          state_d = (zrl_pend_q != '0) ? S_EMIT_ZRL : S_EMIT_SYM;
        end
      end

      S_EMIT_ZRL: begin
        sym_valid = 1'b1;
        sym_run   = ZRL_RUN;
        if (sym_ready) begin
          zrl_pend_d = zrl_pend_q - 2'd1;
          if (zrl_pend_q == 2'd1) state_d = S_EMIT_SYM;
        end
      end

      S_EMIT_SYM: begin
        sym_valid     = 1'b1;
        sym_is_dc     = is_dc_q;
        sym_run       = is_dc_q ? 4'd0 : zero_run_q;
        sym_size      = enc_size;
        sym_amplitude = enc_amp;
        if (sym_ready) begin
          zero_run_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_FETCH;
          end
        end
      end

      S_EMIT_EOB: begin
        sym_valid = 1'b1;
        sym_run   = EOB_RUN;
        sym_size  = EOB_SIZE;
        if (sym_ready) state_d = S_DONE;
      end

      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign coef_addr  = idx_q;
  assign busy       = (state_q != S_IDLE);
  assign block_done = (state_q == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      zero_run_q <= '0;
      zrl_pend_q <= '0;
      comp_q     <= '0;
      enc_q      <= '0;
      is_dc_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_COMPONENTS; i++) pred_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      zero_run_q <= zero_run_d;
      zrl_pend_q <= zrl_pend_d;
      comp_q     <= comp_d;
      enc_q      <= enc_d;
      is_dc_q    <= is_dc_d;
      for (int unsigned i = 0; i < NUM_COMPONENTS; i++) pred_q[i] <= pred_d[i];
    end
  end

endmodule

// File: tb/tb_coefficient_run_sequencer.sv
module tb_coefficient_run_sequencer;

  typedef struct packed {
    logic        is_dc;
    logic [3:0]  run;
    logic [3:0]  size;
    logic [15:0] amp;
  } sym_t;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [1:0]         component_id = '0;
  logic               dc_clear = 1'b0;
  logic [5:0]         coef_addr;
  logic signed [15:0] coef_data = '0;
  logic               sym_valid;
  logic               sym_ready = 1'b0;
  logic               sym_is_dc;
  logic [3:0]         sym_run;
  logic [3:0]         sym_size;
  logic [15:0]        sym_amplitude;
  logic               busy;
  logic               block_done;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] mem [64];
  logic signed [15:0] model_pred [3];
  sym_t obs_q[$];
  sym_t exp_q[$];
  int   done_pulses, stable_err, busy_err;
  bit   timed_out;
  logic post_busy, post_done;

  coefficient_run_sequencer #(.NUM_COMPONENTS(3), .COMP_W(2)) dut (
    .clock(clock), .reset(reset), .start(start), .component_id(component_id),
    .dc_clear(dc_clear), .coef_addr(coef_addr), .coef_data(coef_data),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_is_dc(sym_is_dc),
    .sym_run(sym_run), .sym_size(sym_size), .sym_amplitude(sym_amplitude),
    .busy(busy), .block_done(block_done)
  );

  always #5 clock = ~clock;

  // Coefficient RAM with one cycle of read latency.
  always @(posedge clock) coef_data <= mem[coef_addr];

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int cat(input int v);
    int m, s;
    m = (v < 0) ? -v : v;
    s = 0;
    while (m >= (1 << s)) s++;
    return s;
  endfunction

  function automatic int ampl(input int v, input int s);
    return (v >= 0) ? v : v + (1 << s) - 1;
  endfunction

  task automatic model_block(input int comp);
    logic signed [15:0] d;
    int v, s, last, prev, r;
    exp_q.delete();
    d = mem[0] - model_pred[comp];
    model_pred[comp] = mem[0];
    v = d;
    s = cat(v);
    exp_q.push_back(sym_t'{is_dc: 1'b1, run: 4'd0, size: 4'(s), amp: 16'(ampl(v, s))});
    last = 0;
    for (int k = 1; k < 64; k++) if (mem[k] != 0) last = k;
    prev = 0;
    for (int k = 1; k <= last; k++) begin
      if (mem[k] != 0) begin
        r = k - prev - 1;
        for (int z = 0; z < r / 16; z++)
          exp_q.push_back(sym_t'{is_dc: 1'b0, run: 4'd15, size: 4'd0, amp: 16'd0});
        v = mem[k];
        s = cat(v);
        exp_q.push_back(sym_t'{is_dc: 1'b0, run: 4'(r % 16), size: 4'(s), amp: 16'(ampl(v, s))});
        prev = k;
      end
    end
    if (last < 63) exp_q.push_back(sym_t'{is_dc: 1'b0, run: 4'd0, size: 4'd0, amp: 16'd0});
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 64; k++) mem[k] = '0;
  endtask

  task automatic fill_random();
    int dens;
    clear_mem();
    dens = $urandom_range(1, 10);
    mem[0] = 16'($signed($urandom_range(0, 4000)) - 2000);
    for (int k = 1; k < 64; k++)
      if ($urandom_range(0, 31) < dens) mem[k] = 16'($signed($urandom_range(0, 600)) - 300);
    if ($urandom_range(0, 3) == 0) mem[63] = 16'($signed($urandom_range(1, 50)));
  endtask

  // Drives one block and records every transferred symbol plus protocol events.
  task automatic run_block(input int comp, input int stall, input bit clr, input bit noise);
    sym_t cur, held;
    bit   have_held, finished;
    int   wait_cnt;
    obs_q.delete();
    done_pulses = 0; stable_err = 0; busy_err = 0; timed_out = 0;
    @(negedge clock);
    component_id = 2'(comp); dc_clear = clr; start = 1'b1; sym_ready = (stall == 0);
    @(negedge clock);
    start = 1'b0; dc_clear = 1'b0;
    have_held = 0; finished = 0; wait_cnt = 0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (busy !== 1'b1) busy_err++;
      if (block_done === 1'b1) begin
        done_pulses++;
        finished = 1;
      end
      if (sym_valid === 1'b1) begin
        cur = {sym_is_dc, sym_run, sym_size, sym_amplitude};
        if (have_held && cur !== held) stable_err++;
        if (!have_held) begin
          held = cur; have_held = 1; wait_cnt = 0;
        end
        if (wait_cnt >= stall) begin
          sym_ready = 1'b1;
          obs_q.push_back(cur);
          have_held = 0;
        end else begin
          sym_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        if (have_held) stable_err++;
        have_held = 0;
        sym_ready = (stall == 0);
      end
      if (noise && !finished) begin
        start        = 1'($urandom_range(0, 1));
        component_id = 2'($urandom_range(0, 3));
        dc_clear     = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0; dc_clear = 1'b0;
      end
      if (!finished) @(negedge clock);
    end
    timed_out = !finished;
    start = 1'b0; dc_clear = 1'b0;
    @(negedge clock);
    post_busy = busy;
    post_done = block_done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({sym_valid, busy, block_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got valid/busy/done=%b expected 000", {sym_valid, busy, block_done});
    end
    checks++;
    if ({coef_addr, sym_is_dc, sym_run, sym_size, sym_amplitude} !== '0) begin
      errors++;
      $display("FAIL reset_fields got addr=%0d run=%0d size=%0d amp=%h expected all 0",
               coef_addr, sym_run, sym_size, sym_amplitude);
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) model_pred[c] = '0;
  endtask

  task automatic test_all_zero();
    clear_mem();
    for (int c = 0; c < 3; c++) model_pred[c] = '0;
    model_block(0);
    run_block(0, 0, 1'b1, 1'b0);
    checks++;
    if (timed_out || obs_q.size() !== 2) begin
      errors++;
      $display("FAIL all_zero_count got %0d symbols (timeout=%0d) expected 2", obs_q.size(), timed_out);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL all_zero_sym[%0d] got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_pulses !== 1 || post_busy !== 1'b0 || post_done !== 1'b0) begin
      errors++;
      $display("FAIL all_zero_done got pulses=%0d busy_after=%b done_after=%b expected 1 0 0",
               done_pulses, post_busy, post_done);
    end
  endtask

  task automatic test_dc_diff();
    sym_t want;
    clear_mem();
    mem[0] = 16'sd5;
    model_block(1);
    run_block(1, 0, 1'b0, 1'b0);
    want = sym_t'{is_dc: 1'b1, run: 4'd0, size: 4'd3, amp: 16'd5};
    checks++;
    if (timed_out || obs_q.size() < 1 || obs_q[0] !== want) begin
      errors++;
      $display("FAIL dc_first got %h (n=%0d) expected %h", (obs_q.size() > 0) ? obs_q[0] : sym_t'('0),
               obs_q.size(), want);
    end
    mem[0] = 16'sd3;
    model_block(1);
    run_block(1, 0, 1'b0, 1'b0);
    want = sym_t'{is_dc: 1'b1, run: 4'd0, size: 4'd2, amp: 16'd1};
    checks++;
    if (timed_out || obs_q.size() < 1 || obs_q[0] !== want) begin
      errors++;
      $display("FAIL dc_second got %h (n=%0d) expected %h", (obs_q.size() > 0) ? obs_q[0] : sym_t'('0),
               obs_q.size(), want);
    end
  endtask

  task automatic test_ac_runs();
    sym_t want [5];
    clear_mem();
    mem[1]  = -16'sd1;
    mem[20] = 16'sd7;
    model_block(2);
    run_block(2, 0, 1'b0, 1'b0);
    want[0] = sym_t'{is_dc: 1'b1, run: 4'd0,  size: 4'd0, amp: 16'd0};
    want[1] = sym_t'{is_dc: 1'b0, run: 4'd0,  size: 4'd1, amp: 16'd0};
    want[2] = sym_t'{is_dc: 1'b0, run: 4'd15, size: 4'd0, amp: 16'd0};
    want[3] = sym_t'{is_dc: 1'b0, run: 4'd2,  size: 4'd3, amp: 16'd7};
    want[4] = sym_t'{is_dc: 1'b0, run: 4'd0,  size: 4'd0, amp: 16'd0};
    checks++;
    if (timed_out || obs_q.size() !== 5) begin
      errors++;
      $display("FAIL ac_count got %0d symbols expected 5", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 5; i++) begin
      checks++;
      if (obs_q[i] !== want[i]) begin
        errors++;
        $display("FAIL ac_sym[%0d] got %h expected %h", i, obs_q[i], want[i]);
      end
    end
  endtask

  task automatic test_last_coef();
    clear_mem();
    mem[63] = 16'sd1;
    model_block(0);
    run_block(0, 0, 1'b0, 1'b0);
    checks++;
    if (timed_out || obs_q.size() !== exp_q.size() || exp_q.size() !== 5) begin
      errors++;
      $display("FAIL idx63_count got %0d symbols expected 5", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL idx63_sym[%0d] got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_pulses !== 1 || busy_err !== 0 || post_busy !== 1'b0) begin
      errors++;
      $display("FAIL idx63_done got pulses=%0d busy_gaps=%0d busy_after=%b expected 1 0 0",
               done_pulses, busy_err, post_busy);
    end
  endtask

  task automatic test_backpressure();
    for (int b = 0; b < 3; b++) begin
      fill_random();
      model_block(b);
      run_block(b, 5, 1'b0, 1'b0);
      checks++;
      if (timed_out || obs_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL stall_count[%0d] got %0d symbols expected %0d", b, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL stall_sym[%0d][%0d] got %h expected %h", b, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (stable_err !== 0 || done_pulses !== 1) begin
        errors++;
        $display("FAIL stall_hold[%0d] got unstable=%0d pulses=%0d expected 0 1", b, stable_err, done_pulses);
      end
    end
  endtask

  task automatic test_back_to_back();
    int comp, stall;
    bit clr;
    for (int b = 0; b < 10; b++) begin
      comp  = $urandom_range(0, 2);
      stall = $urandom_range(0, 2);
      clr   = ($urandom_range(0, 3) == 0);
      if (clr) for (int c = 0; c < 3; c++) model_pred[c] = '0;
      fill_random();
      model_block(comp);
      run_block(comp, stall, clr, 1'b1);
      checks++;
      if (timed_out || obs_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL rand_count[%0d] got %0d symbols expected %0d", b, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_sym[%0d][%0d] got %h expected %h", b, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (stable_err !== 0 || busy_err !== 0 || done_pulses !== 1 || post_busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_proto[%0d] got unstable=%0d busy_gaps=%0d pulses=%0d busy_after=%b expected 0 0 1 0",
                 b, stable_err, busy_err, done_pulses, post_busy);
      end
    end
  endtask

  task automatic test_reset_mid_zrl();
    bit found;
    sym_t want;
    clear_mem();
    mem[0]  = 16'sd50;
    mem[63] = 16'sd1;
    @(negedge clock);
    component_id = 2'd1; start = 1'b1; sym_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 500 && !found; cyc++) begin
      if (sym_valid === 1'b1 && sym_is_dc === 1'b0 && sym_run === 4'd15) begin
        found = 1;
        sym_ready = 1'b0;
      end else begin
        @(negedge clock);
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_zrl_reach got no ZRL within bound expected ZRL");
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (sym_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_zrl_idle got valid=%b busy=%b expected 0 0", sym_valid, busy);
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) model_pred[c] = '0;
    clear_mem();
    mem[0] = 16'sd9;
    model_block(1);
    run_block(1, 0, 1'b0, 1'b0);
    want = sym_t'{is_dc: 1'b1, run: 4'd0, size: 4'd4, amp: 16'd9};
    checks++;
    if (timed_out || obs_q.size() < 1 || obs_q[0] !== want) begin
      errors++;
      $display("FAIL rst_zrl_dc got %h (n=%0d) expected %h", (obs_q.size() > 0) ? obs_q[0] : sym_t'('0),
               obs_q.size(), want);
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_all_zero();
    test_dc_diff();
    test_ac_runs();
    test_last_coef();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_zrl();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
